// File: rtl/noc_local_receiver.sv
// NoC local-port receiver: accepts ejected flits, reassembles packets, checks
// destination / ordering / length / payload and reports per-packet status,
// saturating counters and sticky error flags.
module noc_local_receiver #(
  parameter int unsigned X_ID      = 0,
  parameter int unsigned Y_ID      = 0,
  parameter int unsigned Ready_Gap = 0,
  parameter int unsigned Cnt_Width = 16
) (
  input  logic                 noc_clk,
  input  logic                 noc_rst,
  input  logic                 flit_valid,
  input  logic [31:0]          flit_data,
  output logic                 flit_ready,
  input  logic                 err_clr,
  output logic                 pkt_done,
  output logic                 pkt_ok,
  output logic [3:0]           pkt_src_x,
  output logic [3:0]           pkt_src_y,
  output logic [7:0]           pkt_seq,
  output logic [Cnt_Width-1:0] pkt_cnt,
  output logic [Cnt_Width-1:0] err_pkt_cnt,
  output logic [3:0]           err_flags
);

  localparam logic [3:0]     XId    = X_ID[3:0];
  localparam logic [3:0]     YId    = Y_ID[3:0];
  localparam int unsigned    GapM1  = (Ready_Gap > 0) ? Ready_Gap - 1 : 0;
  localparam logic [15:0]    GapLd  = 16'(GapM1);
  localparam logic [Cnt_Width-1:0] CntOne = Cnt_Width'(1);

  localparam logic [1:0] TyBody = 2'b00;
  localparam logic [1:0] TyHead = 2'b01;
  localparam logic [1:0] TyTail = 2'b10;

  // Error bit positions: [0] dest, [1] order, [2] payload, [3] length
  typedef enum logic [1:0] {StIdle, StRecv, StGap} state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  src_x_q, src_x_d;
  logic [3:0]  src_y_q, src_y_d;
  logic [7:0]  seq_q, seq_d;
  logic [5:0]  len_q, len_d;
  logic [3:0]  pkt_err_q, pkt_err_d;
  logic [15:0] gap_q, gap_d;
  // Pending report: a head+tail that arrived while abandoning a packet
  logic        pend_q, pend_d;
  logic        pend_ok_q, pend_ok_d;
  logic [3:0]  pend_sx_q, pend_sx_d;
  logic [3:0]  pend_sy_q, pend_sy_d;
  logic [7:0]  pend_seq_q, pend_seq_d;

  // Flit field decode
  logic [1:0]  typ;
  logic [3:0]  f_sx, f_sy, f_dx, f_dy;
  logic [5:0]  f_len;
  logic [7:0]  f_seq;
  logic        xfer;
  logic        pl_err;
  logic [3:0]  hd_err;

  logic        rep_valid, rep_ok;
  logic [3:0]  rep_sx, rep_sy;
  logic [7:0]  rep_seq;
  logic [3:0]  new_err;
  logic        start_head, finish;
  logic        lerr;
  logic [3:0]  fl_err;

  assign typ   = flit_data[31:30];
  assign f_sx  = flit_data[29:26];
  assign f_sy  = flit_data[25:22];
  assign f_dx  = flit_data[21:18];
  assign f_dy  = flit_data[17:14];
  assign f_len = flit_data[13:8];
  assign f_seq = flit_data[7:0];

  assign flit_ready = (state_q != StGap) && !pend_q;
  assign xfer       = flit_valid && flit_ready;

  // Body/tail payload must echo the captured header and the flit index
  assign pl_err = flit_data[29:0] != {src_x_q, src_y_q, seq_q, 8'd0, idx_q};

  // Errors detectable from a head or head+tail flit alone
  always_comb begin
    hd_err    = 4'b0000;
    hd_err[0] = {f_dx, f_dy} != {XId, YId};
    if (typ == TyHead) hd_err[3] = f_len < 6'd2;
    else               hd_err[3] = f_len != 6'd1;
  end

  // Next-state, report and error-event decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    src_x_d    = src_x_q;
    src_y_d    = src_y_q;
    seq_d      = seq_q;
    len_d      = len_q;
    pkt_err_d  = pkt_err_q;
    gap_d      = gap_q;
    pend_d     = 1'b0;
    pend_ok_d  = pend_ok_q;
    pend_sx_d  = pend_sx_q;
    pend_sy_d  = pend_sy_q;
    pend_seq_d = pend_seq_q;
    rep_valid  = 1'b0;
    rep_ok     = 1'b0;
    rep_sx     = src_x_q;
    rep_sy     = src_y_q;
    rep_seq    = seq_q;
    new_err    = 4'b0000;
    start_head = 1'b0;
    finish     = 1'b0;
    lerr       = 1'b0;
    fl_err     = 4'b0000;

    if (pend_q) begin
      rep_valid = 1'b1;
      rep_ok    = pend_ok_q;
      rep_sx    = pend_sx_q;
      rep_sy    = pend_sy_q;
      rep_seq   = pend_seq_q;
    end

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (typ[0]) start_head = 1'b1;
          else        new_err[1] = 1'b1;
        end
      end
      StRecv: begin
        if (xfer) begin
          unique case (typ)
            TyBody: begin
              lerr      = (idx_q == len_q - 6'd1) || (idx_q == 6'd63);
              fl_err    = {lerr, pl_err, 2'b00};
              new_err   = fl_err;
              pkt_err_d = pkt_err_q | fl_err;
              if (!lerr) idx_d = idx_q + 6'd1;
            end
            TyTail: begin
              lerr      = idx_q != len_q - 6'd1;
              fl_err    = {lerr, pl_err, 2'b00};
              new_err   = fl_err;
              rep_valid = 1'b1;
              rep_ok    = (pkt_err_q | fl_err) == 4'b0000;
              finish    = 1'b1;
            end
            default: begin
              // Head inside a packet: abandon the old one, then start the new one
              new_err[1] = 1'b1;
              rep_valid  = 1'b1;
              rep_ok     = 1'b0;
              start_head = 1'b1;
            end
          endcase
        end
      end
      StGap: begin
        if (gap_q == 16'd0) state_d = StIdle;
        else                gap_d   = gap_q - 16'd1;
      end
      default: state_d = StIdle;
    endcase

    if (start_head) begin
      new_err = new_err | hd_err;
      if (typ == TyHead) begin
        src_x_d   = f_sx;
        src_y_d   = f_sy;
        seq_d     = f_seq;
        len_d     = f_len;
        idx_d     = 6'd1;
        pkt_err_d = hd_err;
        state_d   = StRecv;
      end else begin
        finish = 1'b1;
        if (rep_valid) begin
          // Report slot already taken by the abandoned packet
          pend_d     = 1'b1;
          pend_ok_d  = hd_err == 4'b0000;
          pend_sx_d  = f_sx;
          pend_sy_d  = f_sy;
          pend_seq_d = f_seq;
        end else begin
          rep_valid = 1'b1;
          rep_ok    = hd_err == 4'b0000;
          rep_sx    = f_sx;
          rep_sy    = f_sy;
          rep_seq   = f_seq;
        end
      end
    end

    if (finish) begin
      if (Ready_Gap != 0) begin
        state_d = StGap;
        gap_d   = GapLd;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // State, captured fields, registered report outputs and counters
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      seq_q       <= '0;
      len_q       <= '0;
      pkt_err_q   <= '0;
      gap_q       <= '0;
      pend_q      <= 1'b0;
      pend_ok_q   <= 1'b0;
      pend_sx_q   <= '0;
      pend_sy_q   <= '0;
      pend_seq_q  <= '0;
      pkt_done    <= 1'b0;
      pkt_ok      <= 1'b0;
      pkt_src_x   <= '0;
      pkt_src_y   <= '0;
      pkt_seq     <= '0;
      pkt_cnt     <= '0;
      err_pkt_cnt <= '0;
      err_flags   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      seq_q      <= seq_d;
      len_q      <= len_d;
      pkt_err_q  <= pkt_err_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      pend_ok_q  <= pend_ok_d;
      pend_sx_q  <= pend_sx_d;
      pend_sy_q  <= pend_sy_d;
      pend_seq_q <= pend_seq_d;
      pkt_done   <= rep_valid;
      if (rep_valid) begin
        pkt_ok    <= rep_ok;
        pkt_src_x <= rep_sx;
        pkt_src_y <= rep_sy;
        pkt_seq   <= rep_seq;
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CntOne;
        if (!rep_ok && (err_pkt_cnt != '1)) err_pkt_cnt <= err_pkt_cnt + CntOne;
      end
      // A fresh error in the clearing cycle survives the clear
      err_flags <= (err_clr ? 4'b0000 : err_flags) | new_err;
    end
  end

endmodule

// File: tb/tb_noc_local_receiver.sv
// Scoreboard bench for noc_local_receiver: unit 0 (no ready gap) checks
// packet reports, counters and flags; unit 1 (Ready_Gap=3) checks the gap.
module tb_noc_local_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fv;
  logic [31:0] fd [2];
  logic [1:0]  fr;
  logic        clr;

  logic        done0, ok0, done1, ok1;
  logic [3:0]  sx0, sy0, sx1, sy1, flags0, flags1;
  logic [7:0]  seq0, seq1;
  logic [15:0] cnt0, ecnt0, cnt1, ecnt1;

  always #5 clk = ~clk;

  noc_local_receiver #(.X_ID(1), .Y_ID(2), .Ready_Gap(0), .Cnt_Width(16)) u_dut0 (
    .noc_clk(clk), .noc_rst(rst), .flit_valid(fv[0]), .flit_data(fd[0]),
    .flit_ready(fr[0]), .err_clr(clr), .pkt_done(done0), .pkt_ok(ok0),
    .pkt_src_x(sx0), .pkt_src_y(sy0), .pkt_seq(seq0), .pkt_cnt(cnt0),
    .err_pkt_cnt(ecnt0), .err_flags(flags0)
  );

  noc_local_receiver #(.X_ID(1), .Y_ID(2), .Ready_Gap(3), .Cnt_Width(16)) u_dut1 (
    .noc_clk(clk), .noc_rst(rst), .flit_valid(fv[1]), .flit_data(fd[1]),
    .flit_ready(fr[1]), .err_clr(1'b0), .pkt_done(done1), .pkt_ok(ok1),
    .pkt_src_x(sx1), .pkt_src_y(sy1), .pkt_seq(seq1), .pkt_cnt(cnt1),
    .err_pkt_cnt(ecnt1), .err_flags(flags1)
  );

  typedef struct packed {
    logic        ok;
    logic [3:0]  sx;
    logic [3:0]  sy;
    logic [7:0]  seq;
    logic [31:0] due;
  } exp_t;

  exp_t q[$];
  exp_t nxt;
  exp_t mon_e;
  bit   nxt_v = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_head(input logic [1:0] ty, input logic [3:0] sx,
                                          input logic [3:0] sy, input logic [3:0] dx,
                                          input logic [3:0] dy, input logic [5:0] len,
                                          input logic [7:0] seq);
    return {ty, sx, sy, dx, dy, len, seq};
  endfunction

  function automatic logic [31:0] mk_pl(input logic [1:0] ty, input logic [3:0] sx,
                                        input logic [3:0] sy, input logic [7:0] seq,
                                        input logic [13:0] idx);
    return {ty, sx, sy, seq, idx};
  endfunction

  // Arms a report expectation for the next flit accepted on unit 0
  task automatic expect_rep(input logic ok, input logic [3:0] sx, input logic [3:0] sy,
                            input logic [7:0] seq);
    nxt.ok  = ok;
    nxt.sx  = sx;
    nxt.sy  = sy;
    nxt.seq = seq;
    nxt.due = '0;
    nxt_v   = 1'b1;
  endtask

  task automatic send(input int u, input logic [31:0] d);
    @(negedge clk);
    fv[u] = 1'b1;
    fd[u] = d;
    for (int i = 0; i < 20; i++) begin
      if (fr[u]) break;
      @(negedge clk);
    end
    if (!fr[u]) begin
      check_eq("ready_timeout", {31'd0, fr[u]}, 32'd1);
      fv[u] = 1'b0;
    end else begin
      if (u == 0 && nxt_v) begin
        nxt.due = cyc + 1;
        q.push_back(nxt);
        nxt_v = 1'b0;
        exp_cnt++;
        if (!nxt.ok) exp_err++;
      end
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    fv = 2'b00;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_eq("flags_after_clr", {28'd0, flags0}, 32'd0);
  endtask

  // Report monitor for unit 0
  always @(negedge clk) begin
    if (!rst) begin
      if (done0) begin
        if (q.size() == 0) begin
          check_eq("unexpected_done", {31'd0, done0}, 32'd0);
        end else begin
          mon_e = q.pop_front();
          check_eq("done_cycle", cyc, mon_e.due);
          check_eq("pkt_ok", {31'd0, ok0}, {31'd0, mon_e.ok});
          check_eq("src_x", {28'd0, sx0}, {28'd0, mon_e.sx});
          check_eq("src_y", {28'd0, sy0}, {28'd0, mon_e.sy});
          check_eq("seq", {24'd0, seq0}, {24'd0, mon_e.seq});
        end
      end else if (q.size() > 0 && cyc > q[0].due) begin
        check_eq("missing_done", {31'd0, done0}, 32'd1);
        mon_e = q.pop_front();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fv  = 2'b00;
    fd[0] = '0;
    fd[1] = '0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_ready0", {31'd0, fr[0]}, 32'd1);
    check_eq("rst_ready1", {31'd0, fr[1]}, 32'd1);
    check_eq("rst_done", {31'd0, done0}, 32'd0);
    check_eq("rst_ok", {31'd0, ok0}, 32'd0);
    check_eq("rst_cnt", {16'd0, cnt0}, 32'd0);
    check_eq("rst_ecnt", {16'd0, ecnt0}, 32'd0);
    check_eq("rst_flags", {28'd0, flags0}, 32'd0);
    check_eq("rst_seq", {24'd0, seq0}, 32'd0);

    // Clean three-flit packet
    send(0, 32'h40048305);
    send(0, 32'h00014001);
    expect_rep(1'b1, 4'd0, 4'd0, 8'd5);
    send(0, 32'h80014002);
    idle(2);
    check_eq("good_cnt", {16'd0, cnt0}, exp_cnt);
    check_eq("good_flags", {28'd0, flags0}, 32'd0);

    // Payload error
    send(0, 32'h40048305);
    send(0, 32'h00014003);
    expect_rep(1'b0, 4'd0, 4'd0, 8'd5);
    send(0, 32'h80014002);
    idle(2);
    check_eq("payload_flags", {28'd0, flags0}, 32'h4);
    check_eq("payload_ecnt", {16'd0, ecnt0}, exp_err);
    pulse_clr();

    // Destination error
    send(0, 32'h400C8305);
    send(0, 32'h00014001);
    expect_rep(1'b0, 4'd0, 4'd0, 8'd5);
    send(0, 32'h80014002);
    idle(2);
    check_eq("dest_flags", {28'd0, flags0}, 32'h1);
    pulse_clr();

    // Stray body in IDLE: order error, no report
    send(0, 32'h00014001);
    idle(2);
    check_eq("stray_flags", {28'd0, flags0}, 32'h2);
    pulse_clr();

    // Head mid-packet abandons the first packet; second completes cleanly
    send(0, 32'h40048305);
    send(0, 32'h00014001);
    expect_rep(1'b0, 4'd0, 4'd0, 8'd5);
    send(0, 32'h40048306);
    send(0, 32'h00018001);
    expect_rep(1'b1, 4'd0, 4'd0, 8'd6);
    send(0, 32'h80018002);
    idle(2);
    check_eq("abandon_flags", {28'd0, flags0}, 32'h2);
    check_eq("abandon_cnt", {16'd0, cnt0}, exp_cnt);
    check_eq("abandon_ecnt", {16'd0, ecnt0}, exp_err);
    pulse_clr();

    // Head+tail: length 1 fine, length 2 is a length error
    expect_rep(1'b1, 4'd0, 4'd0, 8'd5);
    send(0, 32'hC0048105);
    expect_rep(1'b0, 4'd0, 4'd0, 8'd5);
    send(0, 32'hC0048205);
    idle(2);
    check_eq("ht_flags", {28'd0, flags0}, 32'h8);
    pulse_clr();

    // Stalled four-flit packet from another source
    send(0, mk_head(2'b01, 4'd3, 4'd4, 4'd1, 4'd2, 6'd4, 8'hA7));
    idle(3);
    send(0, mk_pl(2'b00, 4'd3, 4'd4, 8'hA7, 14'd1));
    idle(1);
    send(0, mk_pl(2'b00, 4'd3, 4'd4, 8'hA7, 14'd2));
    idle(4);
    expect_rep(1'b1, 4'd3, 4'd4, 8'hA7);
    send(0, mk_pl(2'b10, 4'd3, 4'd4, 8'hA7, 14'd3));
    idle(2);
    check_eq("stall_flags", {28'd0, flags0}, 32'h0);

    // Early tail: length error
    send(0, mk_head(2'b01, 4'd3, 4'd4, 4'd1, 4'd2, 6'd3, 8'h11));
    expect_rep(1'b0, 4'd3, 4'd4, 8'h11);
    send(0, mk_pl(2'b10, 4'd3, 4'd4, 8'h11, 14'd1));
    idle(2);
    check_eq("short_flags", {28'd0, flags0}, 32'h8);

    // err_clr together with a new order error: the new bit survives
    @(negedge clk);
    fv[0] = 1'b1;
    fd[0] = 32'h00014001;
    clr   = 1'b1;
    @(negedge clk);
    fv[0] = 1'b0;
    clr   = 1'b0;
    check_eq("clr_race_flags", {28'd0, flags0}, 32'h2);
    check_eq("total_cnt", {16'd0, cnt0}, exp_cnt);
    check_eq("total_ecnt", {16'd0, ecnt0}, exp_err);

    // Ready gap on unit 1
    send(1, 32'h40048305);
    send(1, 32'h00014001);
    send(1, 32'h80014002);
    @(negedge clk);
    fd[1] = 32'h40048306;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("gap_ready_%0d", i), {31'd0, fr[1]}, (i == 3) ? 32'd1 : 32'd0);
      if (i < 3) @(negedge clk);
    end
    @(posedge clk);
    send(1, 32'h00018001);
    send(1, 32'h80018002);
    idle(6);
    check_eq("gap_cnt", {16'd0, cnt1}, 32'd2);
    check_eq("gap_ecnt", {16'd0, ecnt1}, 32'd0);

    // Reset in the middle of a packet
    send(0, 32'h40048305);
    send(0, 32'h00014001);
    @(negedge clk);
    fv  = 2'b00;
    rst = 1'b1;
    exp_cnt = 0;
    exp_err = 0;
    @(negedge clk);
    check_eq("midrst_ready", {31'd0, fr[0]}, 32'd1);
    check_eq("midrst_cnt", {16'd0, cnt0}, 32'd0);
    check_eq("midrst_ecnt", {16'd0, ecnt0}, 32'd0);
    check_eq("midrst_flags", {28'd0, flags0}, 32'd0);
    check_eq("midrst_done", {31'd0, done0}, 32'd0);
    rst = 1'b0;
    idle(3);
    send(0, 32'h40048305);
    send(0, 32'h00014001);
    expect_rep(1'b1, 4'd0, 4'd0, 8'd5);
    send(0, 32'h80014002);
    idle(3);
    check_eq("post_rst_cnt", {16'd0, cnt0}, exp_cnt);
    check_eq("scoreboard_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
